fetch_stage_pipelined: RTL



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_stage_pipelined_if.sv | 24 ++
 rtl/fetch_next_pc.sv | 46 ++++
 rtl/fetch_stage_pipelined.sv | 83 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the fetch stage and its neighbours in the pipeline.
package fetch_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_INSTR_W    = 8;
  localparam int DEF_JUMP_OPC_W = 2;
  localparam int DEF_IMM_W      = DEF_INSTR_W - DEF_JUMP_OPC_W;
  localparam logic [DEF_JUMP_OPC_W-1:0] DEF_JUMP_OPC = 2'b11;

  // Decode reuses this to recognise a local jump in the default configuration.
  function automatic logic is_jump(input logic [DEF_INSTR_W-1:0] instr);
    return instr[DEF_INSTR_W-1 -: DEF_JUMP_OPC_W] == DEF_JUMP_OPC;
  endfunction

endpackage

// File: rtl/fetch_stage_pipelined_if.sv
// Instruction-memory port, redirect request and IF/ID handshake of the fetch stage.
interface fetch_stage_pipelined_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: redirect first, then in-page jump, else PC + 1.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int JUMP_OPC_W = DEF_JUMP_OPC_W,
  parameter logic [JUMP_OPC_W-1:0] JUMP_OPC = DEF_JUMP_OPC
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  next_pc
);
  localparam int IMM_W = INSTR_W - JUMP_OPC_W;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jump_target;
  logic              is_jump;

  assign is_jump = instr[INSTR_W-1 -: JUMP_OPC_W] == JUMP_OPC;
  assign seq_pc  = pc + ADDR_W'(1);

  // The jump immediate replaces only the low PC bits; the page bits above it are kept.
  generate
    if (IMM_W > ADDR_W) begin : g_bad_imm
      $error("fetch_next_pc: IMM_W (%0d) exceeds ADDR_W (%0d)", IMM_W, ADDR_W);
      assign jump_target = '0;
    end else if (IMM_W == ADDR_W) begin : g_full_imm
      assign jump_target = instr[IMM_W-1:0];
    end else begin : g_page_imm
      assign jump_target = {pc[ADDR_W-1:IMM_W], instr[IMM_W-1:0]};
    end
  endgenerate

  always_comb begin
    next_pc = seq_pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (is_jump) begin
      next_pc = jump_target;
    end
  end

endmodule

// File: rtl/fetch_stage_pipelined.sv
// Pipelined fetch stage: PC register, local jump decode and a one-entry IF/ID buffer.
// Define FETCH_JUMP_SQUASH_EN to consume jumps inside fetch instead of forwarding them.
module fetch_stage_pipelined
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int JUMP_OPC_W = DEF_JUMP_OPC_W,
  parameter logic [JUMP_OPC_W-1:0] JUMP_OPC = DEF_JUMP_OPC,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  fetch_stage_pipelined_if.master bus
);
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  next_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               advance;

  generate
    if ($bits(bus.imem_addr) != ADDR_W || $bits(bus.imem_rdata) != INSTR_W) begin : g_bad_if
      $error("fetch_stage_pipelined: interface widths do not match ADDR_W/INSTR_W");
    end
  endgenerate

  fetch_next_pc #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .JUMP_OPC_W(JUMP_OPC_W),
    .JUMP_OPC  (JUMP_OPC)
  ) u_next_pc (
    .pc            (pc),
    .instr         (bus.imem_rdata),
    .redirect_valid(bus.redirect_valid),
    .redirect_pc   (bus.redirect_pc),
    .next_pc       (next_pc)
  );

  // The IF/ID register can take a new entry when it is empty or being drained.
  assign advance = bus.out_ready | ~out_valid;

`ifdef FETCH_JUMP_SQUASH_EN
  logic fetched_jump;
  assign fetched_jump = bus.imem_rdata[INSTR_W-1 -: JUMP_OPC_W] == JUMP_OPC;
`endif

  // Redirect beats stall, which beats a normal advance; reset drops the in-flight entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (bus.redirect_valid) begin
      pc        <= next_pc;
      out_valid <= 1'b0;
    end else if (advance) begin
      pc <= next_pc;
`ifdef FETCH_JUMP_SQUASH_EN
      if (fetched_jump) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b1;
        out_instr <= bus.imem_rdata;
        out_pc    <= pc;
      end
`else
      out_valid <= 1'b1;
      out_instr <= bus.imem_rdata;
      out_pc    <= pc;
`endif
    end
  end

  assign bus.imem_addr = pc;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_instr;
  assign bus.out_pc    = out_pc;

endmodule
